low_freq_queue: RTL and testbench

Circular sample queue that sits directly upstream of the low-pass FIR stage in the equalizer datapath. It stores the most recent left/right 16-bit audio samples arriving at the codec sample rate. On every new sample, once it is full, it streams the window of `READ_CNT` oldest-to-newest samples to the FIR. It produces the `sequencing` strobe and the `lft_out`/`rght_out` sample stream that the FIR multiplies against its coefficient ROM, one sample per clock.

---
 rtl/eq_pkg.sv | 26 ++
 rtl/low_freq_queue_if.sv | 21 ++
 rtl/dualPort1024x32.sv | 43 ++++
 rtl/low_freq_queue.sv | 105 ++++++++++
 tb/tb_low_freq_queue.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared constants, types and FSM encoding for the equalizer sample queues
package eq_pkg;

    localparam int DEPTH    = 1024;
    localparam int ADDR_W   = 10;
    localparam int READ_CNT = 1021;
    localparam int CNT_W    = $clog2(READ_CNT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } queue_state_t;

    typedef logic [ADDR_W-1:0] ptr_t;

    typedef struct packed {
        logic [15:0] lft;
        logic [15:0] rght;
    } smpl_t;

    // Pointers wrap naturally because DEPTH is a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/low_freq_queue_if.sv
// rtl/low_freq_queue_if.sv - sample-in / window-out bundle between codec side and FIR
interface low_freq_queue_if;

    logic signed [15:0] lft_smpl;
    logic signed [15:0] rght_smpl;
    logic               wrt_smpl;
    logic signed [15:0] lft_out;
    logic signed [15:0] rght_out;
    logic               sequencing;

    modport master (
        output lft_smpl, rght_smpl, wrt_smpl,
        input  lft_out, rght_out, sequencing
    );

    modport slave (
        input  lft_smpl, rght_smpl, wrt_smpl,
        output lft_out, rght_out, sequencing
    );

endinterface

// File: rtl/dualPort1024x32.sv
// rtl/dualPort1024x32.sv - sample storage, independent sync write and registered sync read
module dualPort1024x32
    import eq_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  ptr_t  waddr,
    input  smpl_t wdata,
    input  logic  re,
    input  ptr_t  raddr,
    output smpl_t rdata
);

    smpl_t mem [DEPTH];
    smpl_t rdata_q;
    smpl_t rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its last word when not reading so the FIR sees a stable bus.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/low_freq_queue.sv
// rtl/low_freq_queue.sv - circular sample queue streaming the oldest-to-newest window to the LP FIR
module low_freq_queue
    import eq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    low_freq_queue_if.slave  bus
);

    localparam ptr_t             LAST_FILL = ptr_t'(READ_CNT - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(READ_CNT);

    ptr_t             new_ptr_q, new_ptr_d;
    ptr_t             old_ptr_q, old_ptr_d;
    ptr_t             rd_ptr_q,  rd_ptr_d;
    logic             full_q,    full_d;
    queue_state_t     state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             rd_en;
    logic             trigger;
    smpl_t            wr_word;
    smpl_t            rd_word;

    assign wr_word = '{lft: bus.lft_smpl, rght: bus.rght_smpl};

    // Until full, old_ptr stays at 0, so new_ptr alone counts the fill.
    always_comb begin
        new_ptr_d = new_ptr_q;
        old_ptr_d = old_ptr_q;
        full_d    = full_q;
        if (bus.wrt_smpl) begin
            new_ptr_d = ptr_inc(new_ptr_q);
            if (full_q) begin
                old_ptr_d = ptr_inc(old_ptr_q);
            end
            if (new_ptr_q == LAST_FILL) begin
                full_d = 1'b1;
            end
        end
    end

    assign trigger = bus.wrt_smpl & full_d;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d  = READ;
                    rd_ptr_d = old_ptr_d;
                    cnt_d    = '0;
                end
            end
            READ: begin
                rd_en    = 1'b1;
                rd_ptr_d = ptr_inc(rd_ptr_q);
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_ptr_q <= '0;
            old_ptr_q <= '0;
            rd_ptr_q  <= '0;
            full_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
        end else begin
            new_ptr_q <= new_ptr_d;
            old_ptr_q <= old_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            full_q    <= full_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    dualPort1024x32 u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.wrt_smpl),
        .waddr (new_ptr_q),
        .wdata (wr_word),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    assign bus.sequencing = (state_q == READ);
    assign bus.lft_out    = rd_word.lft;
    assign bus.rght_out   = rd_word.rght;

endmodule

// File: tb/tb_low_freq_queue.sv
// tb/tb_low_freq_queue.sv - self-checking bench for low_freq_queue against a sample-history model
module tb_low_freq_queue;
    import eq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    low_freq_queue_if bus ();

    low_freq_queue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: the last READ_CNT written words, and a snapshot taken at each trigger.
    logic [31:0] hist [$];
    logic [31:0] win  [$];
    bit          m_active;
    int          m_k;
    int          hi_cnt;
    int          win_err;
    int          bad_k;
    logic [31:0] bad_got;
    logic [31:0] bad_exp;
    int          spur;
    logic [15:0] first_l;
    logic [15:0] last_l;
    int          n;

    typedef struct {
        bit          rst_n;
        bit          wrt;
        bit          chk_data;
        bit          exp_seq;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        win.delete();
        m_active = 0;
        m_k      = 0;
        hi_cnt   = 0;
        win_err  = 0;
        spur     = 0;
    endtask

    task automatic tick(input bit w, input logic [15:0] l, input logic [15:0] r);
        bit          was_active;
        bit          ended;
        logic [31:0] got;
        bus.wrt_smpl  = w;
        bus.lft_smpl  = l;
        bus.rght_smpl = r;
        @(posedge clk);
        was_active = m_active;
        ended      = 0;
        if (m_active) begin
            m_k++;
            if (m_k > READ_CNT) begin
                m_active = 0;
                ended    = 1;
            end
        end
        if (w && rst_n) begin
            hist.push_back({l, r});
            if (hist.size() > READ_CNT) void'(hist.pop_front());
            if (hist.size() == READ_CNT && !was_active) begin
                win      = hist;
                m_active = 1;
                m_k      = 0;
                hi_cnt   = 0;
                win_err  = 0;
            end
        end
        @(negedge clk);
        bus.wrt_smpl = 1'b0;
        if (m_active) begin
            if (bus.sequencing === 1'b1) hi_cnt++;
            if (m_k >= 1) begin
                got = {bus.lft_out, bus.rght_out};
                if (got !== win[m_k-1]) begin
                    if (win_err == 0) begin
                        bad_k   = m_k;
                        bad_got = got;
                        bad_exp = win[m_k-1];
                    end
                    win_err++;
                end
                if (m_k == 1)        first_l = bus.lft_out;
                if (m_k == READ_CNT) last_l  = bus.lft_out;
            end
        end else if (bus.sequencing !== 1'b0) begin
            spur++;
        end
        if (ended) begin
            check("pulse_len", hi_cnt, READ_CNT + 1);
            checks++;
            if (win_err != 0) begin
                errors++;
                $display("FAIL window: %0d bad cycles, first at k=%0d got %h expected %h",
                         win_err, bad_k, bad_got, bad_exp);
            end
        end
    endtask

    task automatic idle(input int c);
        repeat (c) tick(1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic wr();
        tick(1'b1, n[15:0], 16'($urandom));
        n++;
    endtask

    // Runs the current readout to completion, optionally writing len samples from cycle start.
    task automatic readout(input int start, input int len);
        int written = 0;
        int guard   = 0;
        while (m_active && guard < READ_CNT + 10) begin
            if (m_k >= start && written < len) begin
                wr();
                written++;
            end else begin
                tick(1'b0, 16'($urandom), 16'($urandom));
            end
            guard++;
        end
        idle(2);
    endtask

    task automatic check_spur(input string name);
        check(name, spur, 0);
        spur = 0;
    endtask

    initial begin
        int base;
        bus.wrt_smpl  = 1'b0;
        bus.lft_smpl  = '0;
        bus.rght_smpl = '0;
        n = 0;
        model_reset();

        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};

        for (int i = 0; i < 6; i++) begin
            rst_n = vecs[i].rst_n;
            tick(vecs[i].wrt, 16'($urandom), 16'($urandom));
            check($sformatf("vec%0d_seq", i), bus.sequencing, vecs[i].exp_seq);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_lft", i),  bus.lft_out,  vecs[i].exp_l);
                check($sformatf("vec%0d_rght", i), bus.rght_out, vecs[i].exp_r);
            end
        end

        // Fill with random gaps: no sequencing until the READ_CNT-th write.
        for (int i = 0; i < READ_CNT - 1; i++) begin
            wr();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        check_spur("fill_quiet");
        wr();
        check("fill_seq_rise", bus.sequencing, 1);
        readout(READ_CNT + 100, 0);
        check("fill_first_l", first_l, 0);
        check("fill_last_l", last_l, 1020);
        check_spur("fill_after");

        wr();
        readout(READ_CNT + 100, 0);
        check("steady_first_l", first_l, 1);
        check("steady_last_l", last_l, 1021);

        // Single write mid-readout: no retrigger, next window shifts by one.
        wr();
        readout(500, 1);
        check("wdr_first_l", first_l, 2);
        check("wdr_last_l", last_l, 1022);
        check_spur("wdr_no_retrigger");
        wr();
        readout($urandom_range(600, 620), 400);
        check("wdr_next_first_l", first_l, 4);
        check("wdr_next_last_l", last_l, 1024);

        wr();
        readout($urandom_range(600, 620), 400);
        wr();
        readout($urandom_range(600, 620), 2099 - n + 1);
        wr();
        readout(READ_CNT + 100, 0);
        check("wrap_first_l", first_l, 1080);
        check("wrap_last_l", last_l, 2100);
        check_spur("wrap_quiet");

        // Asynchronous reset in the middle of a readout.
        wr();
        while (m_active && m_k < 300) tick(1'b0, 16'($urandom), 16'($urandom));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_seq", bus.sequencing, 0);
        check("rst_mid_lft", bus.lft_out, 0);
        check("rst_mid_rght", bus.rght_out, 0);
        model_reset();
        repeat (2) tick(1'b1, 16'($urandom), 16'($urandom));
        rst_n = 1'b1;
        idle(2);
        base = n;
        for (int i = 0; i < READ_CNT - 1; i++) wr();
        check_spur("refill_quiet");
        wr();
        check("refill_seq_rise", bus.sequencing, 1);
        readout(READ_CNT + 100, 0);
        check("refill_first_l", first_l, 32'(base[15:0]));
        check("refill_last_l", last_l, 32'(16'(base + 1020)));
        check_spur("refill_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
